dmem_ctrl: RTL and testbench

//  Data-memory access controller feeding the execute stage's dmem_out (mem_ready/mem_rdata).

---
 rtl/dmem_ctrl_pkg.sv | 42 ++++
 rtl/dmem_ctrl_align.sv | 37 +++
 rtl/dmem_ctrl.sv | 123 ++++++++++++
 tb/tb_dmem_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory access controller: FSM states, access sizes,
// the registered controller state and the response bundle seen by the execute stage.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } dmem_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } mem_out_type;

  typedef struct packed {
    dmem_state_t state;
    logic        bus_valid;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    mem_out_type mem_out;
  } dmem_ctrl_reg_type;

  localparam dmem_ctrl_reg_type init_dmem_ctrl_reg = '{
    state:     IDLE,
    bus_valid: 1'b0,
    bus_write: 1'b0,
    bus_addr:  32'h0,
    bus_wdata: 32'h0,
    bus_wstrb: 4'h0,
    mem_out:   '{ready: 1'b0, rdata: 32'h0, error: 1'b0}
  };

endpackage

// File: rtl/dmem_ctrl_align.sv
// Combinational lane builder: byte strobes, replicated store data and the
// misalignment flag for one request.
module dmem_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    wstrb_o      = 4'b0000;
    wdata_o      = wdata_i;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_B: begin
        wstrb_o = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        wstrb_o      = 4'b0011 << addr_i;
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = addr_i[0];
      end
      SZ_W: begin
        wstrb_o      = 4'b1111;
        misaligned_o = (addr_i != 2'b00);
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding load/store controller between the pipeline and the data bus,
// with misalignment reporting, bus timeout and flush draining.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        clear,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error,
  output logic        bus_valid,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam bit               TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  dmem_ctrl_reg_type r_q, r_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]        al_wstrb;
  logic [31:0]       al_wdata;
  logic              al_misaligned;
  logic              timeout_hit;

  dmem_align u_align (
    .size_i       (req_size),
    .addr_i       (req_addr[1:0]),
    .wdata_i      (req_wdata),
    .wstrb_o      (al_wstrb),
    .wdata_o      (al_wdata),
    .misaligned_o (al_misaligned)
  );

  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = TMO_EN && (cnt_q == TMO_LAST);

  always_comb begin
    r_d               = r_q;
    cnt_d             = cnt_q;
    r_d.mem_out.ready = 1'b0;
    r_d.mem_out.error = 1'b0;
    case (r_q.state)
      IDLE: begin
        if (req_valid && !clear) begin
          if (al_misaligned) begin
            r_d.state         = RESP;
            r_d.mem_out.ready = 1'b1;
            r_d.mem_out.error = 1'b1;
          end else begin
            r_d.state     = WAIT;
            cnt_d         = '0;
            r_d.bus_valid = 1'b1;
            r_d.bus_write = req_store;
            r_d.bus_addr  = {req_addr[31:2], 2'b00};
            r_d.bus_wdata = al_wdata;
            r_d.bus_wstrb = req_store ? al_wstrb : 4'b0000;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // A flush in the same cycle as completion or timeout discards the response outright.
        if (bus_ready || timeout_hit) begin
          r_d.bus_valid = 1'b0;
          if (clear) begin
            r_d.state = IDLE;
          end else begin
            r_d.state         = RESP;
            r_d.mem_out.ready = 1'b1;
            r_d.mem_out.error = !bus_ready;
            if (bus_ready) r_d.mem_out.rdata = r_q.bus_write ? 32'h0 : bus_rdata;
          end
        end else if (clear) begin
          r_d.state = DRAIN;
          cnt_d     = '0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if (bus_ready || timeout_hit) begin
          r_d.bus_valid = 1'b0;
          r_d.state     = IDLE;
        end
      end
      default: r_d.state = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= init_dmem_ctrl_reg;
      cnt_q <= '0;
    end else begin
      r_q   <= r_d;
      cnt_q <= cnt_d;
    end
  end

  assign mem_ready = r_q.mem_out.ready;
  assign mem_rdata = r_q.mem_out.rdata;
  assign mem_error = r_q.mem_out.error;
  assign bus_valid = r_q.bus_valid;
  assign bus_write = r_q.bus_write;
  assign bus_addr  = r_q.bus_addr;
  assign bus_wdata = r_q.bus_wdata;
  assign bus_wstrb = r_q.bus_wstrb;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_store, clear;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_ready, mem_error;
  logic [31:0] mem_rdata;
  logic        bus_valid, bus_write;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(8), .CNT_W(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_store (req_store),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .clear     (clear),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_error (mem_error),
    .bus_valid (bus_valid),
    .bus_write (bus_write),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic st, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
    req_valid = 1'b1;
    req_store = st;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
  endtask

  task automatic drop_req();
    req_valid = 1'b0;
  endtask

  // Misaligned cases: {size, addr}
  logic [1:0]  mis_size [3] = '{2'd1, 2'd2, 2'd3};
  logic [31:0] mis_addr [3] = '{32'h101, 32'h102, 32'h100};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
    req_addr = '0; req_wdata = '0; clear = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_bus_valid", {31'b0, bus_valid}, 32'd0);
    check("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'h0);
    rst = 1'b0;

    // 1: word load, bus_ready three cycles after bus_valid rises
    @(negedge clk); drive_req(1'b0, 2'd2, 32'h100, 32'h0);
    @(negedge clk);
    check("t1_bus_valid", {31'b0, bus_valid}, 32'd1);
    check("t1_bus_write", {31'b0, bus_write}, 32'd0);
    check("t1_bus_addr", bus_addr, 32'h100);
    check("t1_bus_wstrb", {28'b0, bus_wstrb}, 32'h0);
    repeat (2) @(negedge clk);
    check("t1_not_ready", {31'b0, mem_ready}, 32'd0);
    @(negedge clk); bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk); bus_ready = 1'b0; drop_req();
    check("t1_ready", {31'b0, mem_ready}, 32'd1);
    check("t1_error", {31'b0, mem_error}, 32'd0);
    check("t1_rdata", mem_rdata, 32'hDEADBEEF);
    check("t1_bus_drop", {31'b0, bus_valid}, 32'd0);
    @(negedge clk);
    check("t1_one_pulse", {31'b0, mem_ready}, 32'd0);
    check("t1_rdata_hold", mem_rdata, 32'hDEADBEEF);

    // 2: byte store to lane 3, immediate bus_ready
    drive_req(1'b1, 2'd0, 32'h203, 32'h000000AB);
    @(negedge clk);
    check("t2_bus_addr", bus_addr, 32'h200);
    check("t2_bus_wstrb", {28'b0, bus_wstrb}, 32'h8);
    check("t2_bus_wdata", bus_wdata, 32'hABABABAB);
    check("t2_bus_write", {31'b0, bus_write}, 32'd1);
    bus_ready = 1'b1;
    @(negedge clk); bus_ready = 1'b0; drop_req();
    check("t2_ready", {31'b0, mem_ready}, 32'd1);
    check("t2_rdata_zero", mem_rdata, 32'h0);
    @(negedge clk);

    // 2b: half store to upper half
    drive_req(1'b1, 2'd1, 32'h102, 32'hFFFF1234);
    @(negedge clk);
    check("t2b_bus_wstrb", {28'b0, bus_wstrb}, 32'hC);
    check("t2b_bus_wdata", bus_wdata, 32'h12341234);
    bus_ready = 1'b1;
    @(negedge clk); bus_ready = 1'b0; drop_req();
    check("t2b_ready", {31'b0, mem_ready}, 32'd1);
    @(negedge clk);

    // 3: misaligned requests answer with an error and no bus traffic
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, mis_size[i], mis_addr[i], 32'h0);
      @(negedge clk); drop_req();
      check($sformatf("t3_ready_%0d", i), {31'b0, mem_ready}, 32'd1);
      check($sformatf("t3_error_%0d", i), {31'b0, mem_error}, 32'd1);
      check($sformatf("t3_no_bus_%0d", i), {31'b0, bus_valid}, 32'd0);
      @(negedge clk);
      check($sformatf("t3_idle_%0d", i), {30'b0, bus_valid, mem_ready}, 32'd0);
    end

    // 4: timeout after 8 WAIT cycles
    drive_req(1'b0, 2'd2, 32'h300, 32'h0);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_valid && !mem_ready) hi++;
    end
    @(negedge clk); drop_req();
    check("t4_wait_cycles", hi, 32'd8);
    check("t4_ready", {31'b0, mem_ready}, 32'd1);
    check("t4_error", {31'b0, mem_error}, 32'd1);
    check("t4_bus_drop", {31'b0, bus_valid}, 32'd0);
    @(negedge clk);

    // 4b: clear while idle blocks issue
    drive_req(1'b0, 2'd2, 32'h340, 32'h0); clear = 1'b1;
    @(negedge clk); drop_req(); clear = 1'b0;
    check("t4b_no_issue", {30'b0, bus_valid, mem_ready}, 32'd0);

    // 5: flush in the 2nd WAIT cycle, bus answers 4 cycles later; next request waits for drain
    drive_req(1'b0, 2'd2, 32'h400, 32'h0);
    @(negedge clk);
    @(negedge clk); clear = 1'b1; drop_req();
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        clear = 1'b0;
        drive_req(1'b0, 2'd2, 32'h500, 32'h0);
      end
      if (bus_valid && !mem_ready && bus_addr == 32'h400) hi++;
      if (i == 3) begin
        bus_ready = 1'b1; bus_rdata = 32'hBADBAD00;
      end
    end
    check("t5_drain_cycles", hi, 32'd4);
    @(negedge clk); bus_ready = 1'b0;
    check("t5_drained", {30'b0, bus_valid, mem_ready}, 32'd0);
    check("t5_discarded", mem_rdata, 32'h0);
    @(negedge clk);
    check("t5_reissue_valid", {31'b0, bus_valid}, 32'd1);
    check("t5_reissue_addr", bus_addr, 32'h500);
    bus_ready = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk); bus_ready = 1'b0; drop_req();
    check("t5_ready", {31'b0, mem_ready}, 32'd1);
    check("t5_rdata", mem_rdata, 32'hCAFEF00D);
    @(negedge clk);

    // 6: asynchronous reset mid-WAIT, late bus_ready ignored, then a normal load
    drive_req(1'b0, 2'd2, 32'h600, 32'h0);
    @(negedge clk);
    check("t6_wait", {31'b0, bus_valid}, 32'd1);
    #2 rst = 1'b1; drop_req();
    #1;
    check("t6_async_bus_valid", {31'b0, bus_valid}, 32'd0);
    check("t6_async_bus_addr", bus_addr, 32'h0);
    check("t6_async_rdata", mem_rdata, 32'h0);
    @(negedge clk); rst = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h55555555;
    @(negedge clk); bus_ready = 1'b0;
    check("t6_late_ignored", {30'b0, bus_valid, mem_ready}, 32'd0);
    drive_req(1'b0, 2'd2, 32'h700, 32'h0);
    @(negedge clk);
    check("t6_reissue_addr", bus_addr, 32'h700);
    bus_ready = 1'b1; bus_rdata = 32'h13579BDF;
    @(negedge clk); bus_ready = 1'b0; drop_req();
    check("t6_ready", {31'b0, mem_ready}, 32'd1);
    check("t6_rdata", mem_rdata, 32'h13579BDF);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
